key_press_classifier: RTL and testbench

- Downstream stage of the key debouncer.
- Consumes the debouncer's one-cycle press pulse and its debounced key level (active-low).
- Classifies each gesture as single click, double click, or long press, and emits auto-repeat pulses while a long press is held.
- Outputs are one-cycle strobes for LED and display control logic at 12 MHz.

---
 rtl/key_evt_pkg.sv | 31 +++
 rtl/key_press_classifier_if.sv | 23 ++
 rtl/key_dur_timer.sv | 28 ++
 rtl/key_press_classifier.sv | 112 +++++++++++
 tb/tb_key_press_classifier.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/key_evt_pkg.sv
// Shared definitions for the key press classifier: FSM encoding and timing constants.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package key_evt_pkg;

    // Binary 3-bit state encoding; codes 5..7 are unreachable and recover to IDLE.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        WAIT2  = 3'd2,
        PRESS2 = 3'd3,
        HOLD   = 3'd4
    } state_t;

    // Real-time constants for a 12 MHz clock.
    localparam int unsigned CNT_W_12M      = 24;
    localparam int unsigned LONG_CYC_12M   = 12_000_000;   // 1 s
    localparam int unsigned DBL_CYC_12M    = 3_600_000;    // 300 ms
    localparam int unsigned REPEAT_CYC_12M = 2_400_000;    // 200 ms

    // Shortened constants so a simulation walks every path in a few hundred cycles.
    localparam int unsigned LONG_SIM   = 20;
    localparam int unsigned DBL_SIM    = 10;
    localparam int unsigned REPEAT_SIM = 5;

    // A duration count is usable when the counter can reach count-1 without wrapping.
    function automatic bit cyc_ok(input int unsigned cyc, input int unsigned w);
        return (cyc >= 2) && (longint'(cyc) < (longint'(1) << w));
    endfunction

endpackage

// File: rtl/key_press_classifier_if.sv
// Event bundle between debouncer, classifier and LED/display control.
// Latency: n/a (wires only).
// Backpressure: none; all signals are single-cycle strobes or levels.
// Ports: key_pulse/key_lvl come from the debouncer; the four strobes and busy go downstream.
interface key_press_classifier_if;
    logic key_pulse;     // one-cycle press event
    logic key_lvl;       // debounced level, 0 = pressed
    logic single_click;
    logic double_click;
    logic long_press;
    logic repeat_tick;
    logic busy;

    modport master (
        output key_pulse, key_lvl,
        input  single_click, double_click, long_press, repeat_tick, busy
    );

    modport slave (
        input  key_pulse, key_lvl,
        output single_click, double_click, long_press, repeat_tick, busy
    );
endinterface

// File: rtl/key_dur_timer.sv
// Duration counter with clear/enable and terminal-count compare against a supplied threshold.
// Latency: tc is combinational from the count register; clear takes effect on the next edge.
// Backpressure: none; saturates at all-ones instead of wrapping.
// Ports: clk, rst (async active-low), clr, en, thresh in; tc out.
module key_dur_timer #(
    parameter int unsigned CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] thresh,
    output logic             tc
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == thresh);
endmodule

// File: rtl/key_press_classifier.sv
// Classifies debounced key gestures into single/double click and long press, with auto-repeat.
// Latency: strobes registered on the FSM transition edge; long_press LONG_CYC after press entry.
// Backpressure: none; strobes are one-cycle and cannot be stalled.
// Ports: clk, rst (async active-low), kif.slave (key_pulse/key_lvl in; strobes and busy out).
module key_press_classifier
    import key_evt_pkg::*;
#(
    parameter int unsigned CNT_W      = CNT_W_12M,
    parameter int unsigned LONG_CYC   = LONG_CYC_12M,
    parameter int unsigned DBL_CYC    = DBL_CYC_12M,
    parameter int unsigned REPEAT_CYC = REPEAT_CYC_12M
) (
    input  logic                   clk,
    input  logic                   rst,
    key_press_classifier_if.slave  kif
);
    if (!cyc_ok(LONG_CYC, CNT_W))   begin : g_bad_long   $error("LONG_CYC out of range");   end
    if (!cyc_ok(DBL_CYC, CNT_W))    begin : g_bad_dbl    $error("DBL_CYC out of range");    end
    if (!cyc_ok(REPEAT_CYC, CNT_W)) begin : g_bad_repeat $error("REPEAT_CYC out of range"); end

    state_t           state, state_nxt;
    logic             cnt_clr, tc;
    logic [CNT_W-1:0] thresh;
    logic             sc_nxt, dc_nxt, lp_nxt, rt_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            kif.single_click <= 1'b0;
            kif.double_click <= 1'b0;
            kif.long_press   <= 1'b0;
            kif.repeat_tick  <= 1'b0;
        end else begin
            state            <= state_nxt;
            kif.single_click <= sc_nxt;
            kif.double_click <= dc_nxt;
            kif.long_press   <= lp_nxt;
            kif.repeat_tick  <= rt_nxt;
        end
    end

    // Threshold the timer compares against depends only on the current state.
    always_comb begin
        thresh = '0;
        case (state)
            PRESS1:  thresh = CNT_W'(LONG_CYC - 1);
            WAIT2:   thresh = CNT_W'(DBL_CYC - 1);
            HOLD:    thresh = CNT_W'(REPEAT_CYC - 1);
            default: thresh = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        sc_nxt    = 1'b0;
        dc_nxt    = 1'b0;
        lp_nxt    = 1'b0;
        rt_nxt    = 1'b0;
        cnt_clr   = 1'b0;
        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (kif.key_pulse) state_nxt = PRESS1;
            end
            PRESS1: begin
                // Release is checked first so it wins over the long-press threshold.
                if (kif.key_lvl) begin
                    state_nxt = WAIT2;
                end else if (tc) begin
                    state_nxt = HOLD;
                    lp_nxt    = 1'b1;
                end
            end
            WAIT2: begin
                // A second press on the timeout cycle still counts as a double click.
                if (kif.key_pulse) begin
                    state_nxt = PRESS2;
                end else if (tc) begin
                    state_nxt = IDLE;
                    sc_nxt    = 1'b1;
                end
            end
            PRESS2: begin
                if (kif.key_lvl) begin
                    state_nxt = IDLE;
                    dc_nxt    = 1'b1;
                end
            end
            HOLD: begin
                if (kif.key_lvl) begin
                    state_nxt = IDLE;
                end else if (tc) begin
                    rt_nxt  = 1'b1;
                    cnt_clr = 1'b1;   // restart the repeat period without leaving HOLD
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (state_nxt != state) cnt_clr = 1'b1;
    end

    key_dur_timer #(.CNT_W(CNT_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .en     (state != IDLE),
        .thresh (thresh),
        .tc     (tc)
    );

    assign kif.busy = (state != IDLE);
endmodule

// File: tb/tb_key_press_classifier.sv
// Scoreboarded bench for key_press_classifier at simulation-scale timing.
// Latency: expected strobe edges are computed from the edge that samples each stimulus.
// Backpressure: n/a.
module tb_key_press_classifier;
    import key_evt_pkg::*;

    localparam int unsigned CNT_W = 8;
    localparam int LONG   = 20;
    localparam int DBL    = 10;
    localparam int REPEAT = 5;

    localparam logic [3:0] M_SC = 4'b1000;
    localparam logic [3:0] M_DC = 4'b0100;
    localparam logic [3:0] M_LP = 4'b0010;
    localparam logic [3:0] M_RT = 4'b0001;

    typedef struct {
        logic [3:0] mask;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   edge_n = 0;
    int   se;              // edge that samples the most recently driven inputs
    int   vectors = 0;
    int   miscompares = 0;
    exp_t exp_q[$];

    key_press_classifier_if kif ();

    key_press_classifier #(
        .CNT_W      (CNT_W),
        .LONG_CYC   (LONG),
        .DBL_CYC    (DBL),
        .REPEAT_CYC (REPEAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kif (kif.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    wire [3:0] strobes = {kif.single_click, kif.double_click, kif.long_press, kif.repeat_tick};

    // Monitor: every strobe cycle must match the head of the expectation queue.
    always @(negedge clk) begin
        if (rst && (strobes != 4'b0000)) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL strobe unexpected at edge %0d: got mask %b, expected none", edge_n, strobes);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (strobes !== e.mask || edge_n != e.cyc) begin
                    miscompares++;
                    $display("FAIL strobe: got mask %b at edge %0d, expected mask %b at edge %0d",
                             strobes, edge_n, e.mask, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic expect_evt(input logic [3:0] m, input int c);
        exp_t e;
        e.mask = m;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic p, input logic l);
        @(negedge clk);
        kif.key_pulse = p;
        kif.key_lvl   = l;
        se = edge_n + 1;
    endtask

    task automatic drain(input string name);
        repeat (DBL + 6) drive(1'b0, 1'b1);
        @(negedge clk);
        chk({name, "_busy"}, int'(kif.busy), 0);
        chk({name, "_pending"}, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, r;
        kif.key_pulse = 1'b0;
        kif.key_lvl   = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(kif.busy), 0);
        chk("reset_strobes", int'(strobes), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) drive(1'b0, 1'b1);

        // 1. Single click: 5 cycles low, release, timeout DBL edges later.
        drive(1'b1, 1'b0); p = se;
        repeat (4) drive(1'b0, 1'b0);
        drive(1'b0, 1'b1); r = se;
        expect_evt(M_SC, r + DBL);
        drive(1'b0, 1'b1);
        chk("single_busy_wait2", int'(kif.busy), 1);
        drain("single");

        // 2. Double click: second press 6 cycles after release.
        drive(1'b1, 1'b0);
        repeat (2) drive(1'b0, 1'b0);
        drive(1'b0, 1'b1); r = se;
        repeat (5) drive(1'b0, 1'b1);
        drive(1'b1, 1'b0);
        repeat (2) drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        expect_evt(M_DC, se);
        drain("double");

        // 3. Long press with repeats; release lands on a repeat cycle and wins.
        drive(1'b1, 1'b0); p = se;
        expect_evt(M_LP, p + LONG);
        expect_evt(M_RT, p + LONG + REPEAT);
        expect_evt(M_RT, p + LONG + 2 * REPEAT);
        expect_evt(M_RT, p + LONG + 3 * REPEAT);
        repeat (39) drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        drain("long");

        // 4a. Second press exactly on the WAIT2 timeout cycle.
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b1); r = se;
        repeat (DBL - 1) drive(1'b0, 1'b1);
        drive(1'b1, 1'b0);
        chk("coincide_pulse_edge", se, r + DBL);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        expect_evt(M_DC, se);
        drain("coincide_wait2");

        // 4b. Release exactly on the LONG_CYC-1 count: WAIT2, then single click.
        drive(1'b1, 1'b0); p = se;
        repeat (LONG - 1) drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        chk("coincide_release_edge", se, p + LONG);
        expect_evt(M_SC, p + LONG + DBL);
        drain("coincide_press1");

        // 5. Reset in PRESS2 aborts the gesture asynchronously.
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        @(negedge clk);
        chk("press2_busy", int'(kif.busy), 1);
        #2 rst = 1'b0;
        #1;
        chk("async_reset_busy", int'(kif.busy), 0);
        chk("async_reset_strobes", int'(strobes), 0);
        repeat (3) drive(1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 1'b0);
        repeat (3) drive(1'b0, 1'b0);
        drive(1'b0, 1'b1); r = se;
        expect_evt(M_SC, r + DBL);
        drain("after_reset");

        // 6. Spurious pulses in PRESS1 and HOLD must not disturb timing.
        drive(1'b1, 1'b0); p = se;
        expect_evt(M_LP, p + LONG);
        for (int k = 1; k <= 4; k++) expect_evt(M_RT, p + LONG + k * REPEAT);
        for (int i = 1; i <= 41; i++) drive((i == 5 || i == 12 || i == 27 || i == 33), 1'b0);
        drive(1'b0, 1'b1);
        drain("spurious");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
